// File: rtl/trig_phase_sync.sv
// trig_phase_sync: per-channel trigger phase-lock receiver for coax links.
// Calibrates a phase slot per channel, then turns locked triggers into held levels.
module trig_phase_sync #(
  parameter int NCH      = 16,
  parameter int NPHASE   = 4,
  parameter int CNTW     = 6,
  parameter int LOCK_MIN = 54,
  parameter int HOLD     = 3,
  parameter int HISTW    = 32,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
  input  logic             clk_adc,
  input  logic             nrst,
  input  logic             in_en,
  input  logic [NCH-1:0]   coax_in,
  input  logic             calib,
  input  logic             clear_hist,
  input  logic [CW-1:0]    rd_chan,
  input  logic [1:0]       rd_sel,
  input  logic [PW-1:0]    rd_bin,
  output logic [HISTW-1:0] rd_data,
  output logic [NCH-1:0]   locked,
  output logic [NCH-1:0]   trig_out
);

  logic [NCH-1:0]                      in_r;
  logic [PW-1:0]                       pc;
  logic                                calib_q;
  logic                                cal_start;
  logic                                cal_end;
  logic [NPHASE-1:0][NCH-1:0][CNTW-1:0] rec;
  logic [NCH-1:0][PW-1:0]              phase;
  logic [NCH-1:0][PW-1:0]              ph_n;
  logic [NCH-1:0]                      lock_n;
  logic [NCH-1:0][7:0]                 hold;
  logic [NCH-1:0][7:0]                 hold_n;
  logic [NCH-1:0]                      trig_n;
  logic [NCH-1:0][HISTW-1:0]           trig_cnt;
  logic [NCH-1:0][HISTW-1:0]           orph_cnt;
  logic [HISTW-1:0]                    rd_n;

  assign cal_start = calib & ~calib_q;
  assign cal_end   = ~calib & calib_q;

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      in_r    <= '0;
      pc      <= '0;
      calib_q <= 1'b0;
    end else begin
      in_r    <= coax_in & {NCH{in_en}};
      calib_q <= calib;
      if (pc == PW'(NPHASE - 1)) pc <= '0;
      else                       pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      rec <= '0;
    end else if (cal_start) begin
      rec <= '0;
    end else if (calib) begin
      for (int c = 0; c < NCH; c++)
        if (in_r[c] && rec[pc][c] != '1)
          rec[pc][c] <= rec[pc][c] + 1'b1;
    end
  end

  // Lock needs a single populated slot, and that slot must reach LOCK_MIN.
  always_comb begin : lock_eval
    logic           found;
    logic           multi;
    logic           big;
    logic [PW-1:0]  kk;
    lock_n = '0;
    ph_n   = '0;
    for (int c = 0; c < NCH; c++) begin
      found = 1'b0;
      multi = 1'b0;
      big   = 1'b0;
      kk    = '0;
      for (int k = 0; k < NPHASE; k++) begin
        if (rec[k][c] != '0) begin
          multi = multi | found;
          found = 1'b1;
          big   = (rec[k][c] >= CNTW'(LOCK_MIN));
          kk    = PW'(k);
        end
      end
      lock_n[c] = found & ~multi & big;
      ph_n[c]   = lock_n[c] ? kk : '0;
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      locked <= '0;
      phase  <= '0;
    end else if (cal_start) begin
      locked <= '0;
    end else if (cal_end) begin
      locked <= lock_n;
      phase  <= ph_n;
    end
  end

  always_comb begin
    hold_n = hold;
    trig_n = '0;
    for (int c = 0; c < NCH; c++) begin
      if (calib)
        hold_n[c] = '0;
      else if (in_r[c] && locked[c])
        hold_n[c] = 8'(HOLD);
      else if (!in_r[c] && pc == phase[c] && hold[c] != '0)
        hold_n[c] = hold[c] - 1'b1;
      trig_n[c] = ~calib & (hold_n[c] != '0);
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      hold     <= '0;
      trig_out <= '0;
    end else begin
      hold     <= hold_n;
      trig_out <= trig_n;
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      trig_cnt <= '0;
      orph_cnt <= '0;
    end else if (clear_hist) begin
      trig_cnt <= '0;
      orph_cnt <= '0;
    end else if (!calib) begin
      for (int c = 0; c < NCH; c++) begin
        if (in_r[c] && locked[c] && trig_cnt[c] != '1)
          trig_cnt[c] <= trig_cnt[c] + 1'b1;
        if (in_r[c] && !locked[c] && orph_cnt[c] != '1)
          orph_cnt[c] <= orph_cnt[c] + 1'b1;
      end
    end
  end

  always_comb begin
    rd_n = '0;
    if (int'(rd_chan) < NCH) begin
      unique case (rd_sel)
        2'd0: rd_n = trig_cnt[rd_chan];
        2'd1: rd_n = orph_cnt[rd_chan];
        2'd2: if (int'(rd_bin) < NPHASE)
                rd_n = HISTW'(rec[rd_bin][rd_chan]);
        default: rd_n = HISTW'({locked[rd_chan], phase[rd_chan]});
      endcase
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) rd_data <= '0;
    else       rd_data <= rd_n;
  end

endmodule
